adjust_button_pulser: RTL and testbench

- Front end for the offset-adjust logic. Converts raw up/down push-buttons into clean single-cycle `up`/`down` step pulses.
- Provides synchronization, debounce, press-edge detection and hold-to-auto-repeat.
- Only emits steps while the downstream adjuster reports `adjusting`.

---
 rtl/adjust_button_pulser.sv | 140 ++++++++++++++
 tb/tb_adjust_button_pulser.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adjust_button_pulser.sv
// Button front end for the offset adjuster: sync, debounce, press-edge detect
// and hold-to-auto-repeat, producing single-cycle up/down step pulses.
module adjust_button_pulser #(
  parameter int unsigned DEBOUNCE_CYCLES = 650000,
  parameter int unsigned REPEAT_DELAY    = 32500000,
  parameter int unsigned REPEAT_PERIOD   = 6500000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_up_raw,
  input  logic btn_down_raw,
  input  logic adjusting,
  output logic up,
  output logic down,
  output logic up_level,
  output logic down_level
);

  localparam int unsigned MAX_DR = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int unsigned MAX_P  = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
  localparam int unsigned CW     = $clog2(MAX_P) + 1;

  typedef enum logic [1:0] {
    IDLE,
    HOLD_UP,
    HOLD_DOWN,
    LOCKOUT
  } state_t;

  // Index 0 is the up button, index 1 the down button.
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    level;
  logic [CW-1:0] db_cnt [2];

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] rpt;
  logic [CW-1:0] rpt_next;
  logic          up_next;
  logic          down_next;

  // Two-flop synchronizer and per-button debounce counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1     <= '0;
      sync2     <= '0;
      level     <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      sync1 <= {btn_down_raw, btn_up_raw};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          level[i]  <= ~level[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign up_level   = level[0];
  assign down_level = level[1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rpt   <= '0;
      up    <= 1'b0;
      down  <= 1'b0;
    end else begin
      state <= state_next;
      rpt   <= rpt_next;
      up    <= up_next;
      down  <= down_next;
    end
  end

  // Pulses are registered in the same cycle the press or repeat is recognised.
  always_comb begin
    state_next = state;
    rpt_next   = rpt;
    up_next    = 1'b0;
    down_next  = 1'b0;
    case (state)
      IDLE: begin
        if (level[0] && level[1]) begin
          state_next = LOCKOUT;
        end else if ((level[0] || level[1]) && !adjusting) begin
          state_next = LOCKOUT;
        end else if (level[0]) begin
          state_next = HOLD_UP;
          up_next    = 1'b1;
          rpt_next   = CW'(REPEAT_DELAY);
        end else if (level[1]) begin
          state_next = HOLD_DOWN;
          down_next  = 1'b1;
          rpt_next   = CW'(REPEAT_DELAY);
        end
      end
      HOLD_UP: begin
        if (level[1] || !adjusting) begin
          state_next = LOCKOUT;
        end else if (!level[0]) begin
          state_next = IDLE;
        end else if (rpt == CW'(1)) begin
          up_next  = 1'b1;
          rpt_next = CW'(REPEAT_PERIOD);
        end else begin
          rpt_next = rpt - CW'(1);
        end
      end
      HOLD_DOWN: begin
        if (level[0] || !adjusting) begin
          state_next = LOCKOUT;
        end else if (!level[1]) begin
          state_next = IDLE;
        end else if (rpt == CW'(1)) begin
          down_next = 1'b1;
          rpt_next  = CW'(REPEAT_PERIOD);
        end else begin
          rpt_next = rpt - CW'(1);
        end
      end
      LOCKOUT: begin
        // Held buttons must be fully released before stepping resumes.
        if (!level[0] && !level[1]) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_adjust_button_pulser.sv
// Scoreboard bench for adjust_button_pulser with short debounce/repeat timing.
`timescale 1ns/1ps
module tb_adjust_button_pulser;

  localparam int unsigned DB = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RP = 3;

  logic clock = 1'b0;
  logic reset;
  logic btn_up_raw;
  logic btn_down_raw;
  logic adjusting;
  logic up;
  logic down;
  logic up_level;
  logic down_level;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    bit is_up;
    int at;
  } exp_t;
  exp_t exp_q[$];

  adjust_button_pulser #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clock(clock),
    .reset(reset),
    .btn_up_raw(btn_up_raw),
    .btn_down_raw(btn_down_raw),
    .adjusting(adjusting),
    .up(up),
    .down(down),
    .up_level(up_level),
    .down_level(down_level)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Every high output cycle must match the next expected pulse.
  always @(negedge clock) begin
    exp_t e;
    if (up && down) begin
      n_checks++;
      n_fail++;
      $display("FAIL both_high cyc=%0d up=%b down=%b required at most one high", cyc, up, down);
    end
    if (up || down) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse cyc=%0d up=%b down=%b required no pulse", cyc, up, down);
      end else begin
        e = exp_q.pop_front();
        if (e.is_up !== up || e.at !== cyc) begin
          n_fail++;
          $display("FAIL pulse cyc=%0d up=%b required cyc=%0d up=%b", cyc, up, e.at, e.is_up);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push(input bit is_up, input int at);
    exp_t e;
    e.is_up = is_up;
    e.at    = at;
    exp_q.push_back(e);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    btn_up_raw = 1'b0;
    btn_down_raw = 1'b0;
    adjusting = 1'b1;
    tick(3);
    n_checks++;
    if ({up, down, up_level, down_level} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b required=0000", {up, down, up_level, down_level});
    end
    reset = 1'b0;
    tick(3);
    n_checks++;
    if ({up, down, up_level, down_level} !== 4'b0000) begin
      n_fail++;
      $display("FAIL after_reset_outputs got=%b required=0000", {up, down, up_level, down_level});
    end
  endtask

  task automatic test_clean_press;
    int t0;
    t0 = cyc;
    btn_up_raw = 1'b1;
    push(1'b1, t0 + 7);
    tick(5);
    n_checks++;
    if (up_level !== 1'b0) begin
      n_fail++;
      $display("FAIL clean_level_edge5 got=%b required=0", up_level);
    end
    tick(1);
    n_checks++;
    if (up_level !== 1'b1) begin
      n_fail++;
      $display("FAIL clean_level_edge6 got=%b required=1", up_level);
    end
    tick(2);
    btn_up_raw = 1'b0;
    tick(12);
    n_checks++;
    if (up_level !== 1'b0) begin
      n_fail++;
      $display("FAIL clean_release_level got=%b required=0", up_level);
    end
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL clean_pending got=%0d required=0", exp_q.size());
    end
  endtask

  task automatic test_bounce;
    btn_down_raw = 1'b1; tick(1);
    btn_down_raw = 1'b0; tick(1);
    btn_down_raw = 1'b1; tick(1);
    btn_down_raw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      n_checks++;
      if (down_level !== 1'b0) begin
        n_fail++;
        $display("FAIL bounce_level step=%0d got=%b required=0", i, down_level);
      end
    end
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL bounce_pending got=%0d required=0", exp_q.size());
    end
  endtask

  task automatic test_auto_repeat;
    int t0;
    t0 = cyc;
    btn_up_raw = 1'b1;
    push(1'b1, t0 + 7);
    push(1'b1, t0 + 17);
    push(1'b1, t0 + 20);
    push(1'b1, t0 + 23);
    push(1'b1, t0 + 26);
    push(1'b1, t0 + 29);
    push(1'b1, t0 + 32);
    tick(28);
    btn_up_raw = 1'b0;
    tick(5);
    n_checks++;
    if (up_level !== 1'b1) begin
      n_fail++;
      $display("FAIL repeat_level_tail got=%b required=1", up_level);
    end
    tick(1);
    n_checks++;
    if (up_level !== 1'b0) begin
      n_fail++;
      $display("FAIL repeat_level_fall got=%b required=0", up_level);
    end
    tick(15);
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL repeat_pending got=%0d required=0", exp_q.size());
    end
  endtask

  task automatic test_conflict;
    int t0;
    int t1;
    t0 = cyc;
    btn_up_raw = 1'b1;
    push(1'b1, t0 + 7);
    push(1'b1, t0 + 17);
    tick(12);
    btn_down_raw = 1'b1;
    tick(18);
    n_checks++;
    if ({up_level, down_level} !== 2'b11) begin
      n_fail++;
      $display("FAIL conflict_levels got=%b required=11", {up_level, down_level});
    end
    btn_down_raw = 1'b0;
    tick(15);
    n_checks++;
    if ({up_level, down_level} !== 2'b10) begin
      n_fail++;
      $display("FAIL conflict_down_release got=%b required=10", {up_level, down_level});
    end
    btn_up_raw = 1'b0;
    tick(10);
    n_checks++;
    if ({up_level, down_level} !== 2'b00) begin
      n_fail++;
      $display("FAIL conflict_all_release got=%b required=00", {up_level, down_level});
    end
    t1 = cyc;
    btn_up_raw = 1'b1;
    push(1'b1, t1 + 7);
    tick(8);
    btn_up_raw = 1'b0;
    tick(12);
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL conflict_pending got=%0d required=0", exp_q.size());
    end
  endtask

  task automatic test_gating;
    int t1;
    adjusting = 1'b0;
    btn_up_raw = 1'b1;
    tick(20);
    adjusting = 1'b1;
    tick(10);
    n_checks++;
    if (up_level !== 1'b1) begin
      n_fail++;
      $display("FAIL gating_level got=%b required=1", up_level);
    end
    btn_up_raw = 1'b0;
    tick(10);
    t1 = cyc;
    btn_up_raw = 1'b1;
    push(1'b1, t1 + 7);
    tick(8);
    btn_up_raw = 1'b0;
    tick(12);
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL gating_pending got=%0d required=0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_hold;
    int t0;
    int tr;
    t0 = cyc;
    btn_up_raw = 1'b1;
    push(1'b1, t0 + 7);
    tick(7);
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({up, down, up_level, down_level} !== 4'b0000) begin
      n_fail++;
      $display("FAIL async_reset_outputs got=%b required=0000", {up, down, up_level, down_level});
    end
    tick(2);
    reset = 1'b0;
    tr = cyc;
    push(1'b1, tr + 7);
    tick(5);
    n_checks++;
    if (up_level !== 1'b0) begin
      n_fail++;
      $display("FAIL rehold_level_edge5 got=%b required=0", up_level);
    end
    tick(1);
    n_checks++;
    if (up_level !== 1'b1) begin
      n_fail++;
      $display("FAIL rehold_level_edge6 got=%b required=1", up_level);
    end
    tick(2);
    btn_up_raw = 1'b0;
    tick(12);
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL rehold_pending got=%0d required=0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_conflict();
    test_gating();
    test_reset_mid_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d required finish before limit", cyc);
    $fatal(1, "timeout");
  end

endmodule
